flag_sequencer: RTL and testbench



---
 rtl/flag_sequencer_pkg.sv | 45 ++++
 rtl/flag_button_debounce.sv | 60 ++++++
 rtl/flag_sequencer.sv | 128 ++++++++++++
 tb/tb_flag_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_sequencer_pkg.sv
// Shared widths, default timing constants and selector step helpers for the flag sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package flag_sequencer_pkg;

  // Selector/count width, shared with the flag colour index.
  localparam int SEL_W = 8;

  // Default timing constants.
  localparam int DEBOUNCE_FRAMES_DEF = 2;
  localparam int HOLD_FRAMES_DEF     = 180;

  // Counter widths sized for the legal parameter ranges (1..15 and 1..255).
  localparam int DBC_W  = 4;
  localparam int HOLD_W = 8;

  typedef logic [SEL_W-1:0] sel_t;

  // Outstanding manual request, waiting for the next frame boundary.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_NEXT = 2'd1,
    REQ_PREV = 2'd2
  } req_e;

  // Forward step with wrap. The increment is done at SEL_W+1 bits so that
  // selector=255 cannot wrap to 0 and falsely look in range.
  function automatic sel_t sel_next(input sel_t sel, input sel_t cnt);
    logic [SEL_W:0] inc;
    inc = {1'b0, sel} + {{SEL_W{1'b0}}, 1'b1};
    if (inc >= {1'b0, cnt}) begin
      return '0;
    end
    return inc[SEL_W-1:0];
  endfunction

  // Backward step with wrap; an out-of-range selector lands on the last flag.
  function automatic sel_t sel_prev(input sel_t sel, input sel_t cnt);
    if (sel == '0 || sel >= cnt) begin
      return cnt - sel_t'(1);
    end
    return sel - sel_t'(1);
  endfunction

endpackage

// File: rtl/flag_button_debounce.sv
// Button conditioner: 2-FF synchronizer, frame-sampled debounce, rising-edge pulse.
// Latency: 2 clk sync, then DEBOUNCE_FRAMES frame_start samples; rise is combinational in that frame_start cycle.
// Backpressure: none; rise is a single-cycle pulse that must be consumed when asserted.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   frame_start  one-cycle per-frame sample strobe
//   btn          raw asynchronous button level (1 = pressed)
//   rise         pulse when the debounced level goes 0->1 (only in a frame_start cycle)
module flag_button_debounce
  import flag_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic btn,
  output logic rise
);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [DBC_W-1:0] stab_q;
  logic             differs;
  logic             flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  assign differs = (sync_q2 != level_q);
  // This sample would be the DEBOUNCE_FRAMES-th consecutive differing one.
  assign flip    = frame_start && differs && (stab_q == DBC_W'(DEBOUNCE_FRAMES - 1));
  assign rise    = flip && sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      stab_q  <= '0;
    end else if (frame_start) begin
      if (!differs) begin
        stab_q <= '0;
      end else if (flip) begin
        level_q <= sync_q2;
        stab_q  <= '0;
      end else begin
        stab_q <= stab_q + DBC_W'(1);
      end
    end
  end

endmodule

// File: rtl/flag_sequencer.sv
// Flag selector: turns next/prev buttons and an auto-cycle timer into frame-aligned selector changes.
// Latency: a press debounced at frame_start k commits at frame_start k+1; selector/changed registered.
// Backpressure: none; requests are held pending until the next frame boundary.
//
// Ports:
//   clk, rst_n          pixel clock and async active-low reset
//   frame_start         one-cycle pulse per frame from the VGA timing generator
//   btn_next, btn_prev  raw asynchronous buttons (1 = pressed)
//   auto_en             level, enables auto-advance every HOLD_FRAMES frames
//   count               number of valid flags, from the flag index
//   selector            current flag index (registered)
//   changed             one-cycle pulse in the cycle selector first shows a new value
module flag_sequencer
  import flag_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
  parameter int HOLD_FRAMES     = HOLD_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  input  logic [SEL_W-1:0] count,
  output logic [SEL_W-1:0] selector,
  output logic             changed
);

  logic              rise_next;
  logic              rise_prev;
  req_e              pend_q;
  req_e              pend_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  sel_t              sel_d;
  logic              changed_d;
  logic              commit;
  sel_t              target;

  flag_button_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_dbc_next (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn         (btn_next),
    .rise        (rise_next)
  );

  flag_button_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_dbc_prev (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn         (btn_prev),
    .rise        (rise_prev)
  );

  always_comb begin
    pend_d    = pend_q;
    hold_d    = hold_q;
    sel_d     = selector;
    changed_d = 1'b0;
    commit    = 1'b0;
    target    = selector;

    if (!auto_en) begin
      hold_d = '0;
    end

    if (frame_start) begin
      if (count == '0) begin
        // No valid flags: park at 0 silently, keep any pending request.
        sel_d  = '0;
        hold_d = '0;
      end else if (pend_q == REQ_NEXT) begin
        commit = 1'b1;
        target = sel_next(selector, count);
        pend_d = REQ_NONE;
        hold_d = '0;
      end else if (pend_q == REQ_PREV) begin
        commit = 1'b1;
        target = sel_prev(selector, count);
        pend_d = REQ_NONE;
        hold_d = '0;
      end else if (auto_en) begin
        if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
          commit = 1'b1;
          target = sel_next(selector, count);
          hold_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end

    if (commit) begin
      sel_d     = target;
      changed_d = (target != selector);
    end

    // New edges are captured after the commit so they wait for the next frame.
    if (rise_next && rise_prev) begin
      pend_d = REQ_NONE;
    end else if (rise_next) begin
      pend_d = REQ_NEXT;
    end else if (rise_prev) begin
      pend_d = REQ_PREV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selector <= '0;
      changed  <= 1'b0;
      pend_q   <= REQ_NONE;
      hold_q   <= '0;
    end else begin
      selector <= sel_d;
      changed  <= changed_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_flag_sequencer.sv
module tb_flag_sequencer;

  localparam int DEB  = 2;
  localparam int HOLD = 4;
  localparam int FRAME_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] count = 8'd73;
  logic [7:0] selector;
  logic       changed;

  int checks = 0;
  int failures = 0;

  flag_sequencer #(
    .DEBOUNCE_FRAMES (DEB),
    .HOLD_FRAMES     (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .count       (count),
    .selector    (selector),
    .changed     (changed)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Called at a negedge. Drives one frame's inputs, runs 15 idle cycles
  // (selector must hold and changed must stay low), then one frame_start.
  task automatic do_frame(input bit bn, input bit bp, input bit ae, input int cnt,
                          input int esel, input bit echg, input string tag);
    int         quiet_bad;
    logic [7:0] s0;
    quiet_bad   = 0;
    btn_next    = bn;
    btn_prev    = bp;
    auto_en     = ae;
    count       = cnt[7:0];
    frame_start = 1'b0;
    s0          = selector;
    for (int c = 0; c < FRAME_CLKS - 1; c++) begin
      @(negedge clk);
      if (changed !== 1'b0 || selector !== s0) quiet_bad++;
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check({tag, "_quiet"}, quiet_bad, 0);
    check({tag, "_sel"}, selector, esel);
    check({tag, "_chg"}, changed, echg);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    btn_next    = 1'b0;
    btn_prev    = 1'b0;
    auto_en     = 1'b0;
    count       = 8'd73;
    repeat (3) @(negedge clk);
    check("reset_sel", selector, 0);
    check("reset_chg", changed, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model (one call per frame) ----------------
  bit m_deb[2];
  int m_run[2];
  int m_dir;     // +1 next, -1 prev, 0 nothing waiting
  int m_sel;
  int m_hold;

  function automatic int step(input int sel, input int cnt, input int dir);
    if (dir > 0) return (sel + 1 >= cnt) ? 0 : sel + 1;
    return (sel == 0 || sel >= cnt) ? cnt - 1 : sel - 1;
  endfunction

  task automatic model_reset();
    m_deb[0] = 0; m_deb[1] = 0;
    m_run[0] = 0; m_run[1] = 0;
    m_dir = 0; m_sel = 0; m_hold = 0;
  endtask

  task automatic model_frame(input bit bn, input bit bp, input bit ae, input int cnt,
                             output int esel, output bit echg);
    bit smp[2];
    bit rise[2];
    bit cm;
    int tgt;
    smp[0] = bn;
    smp[1] = bp;
    for (int b = 0; b < 2; b++) begin
      rise[b] = 0;
      if (smp[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_deb[b] = smp[b];
          m_run[b] = 0;
          rise[b]  = smp[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    cm  = 0;
    tgt = m_sel;
    if (!ae) m_hold = 0;
    if (cnt == 0) begin
      m_sel  = 0;
      m_hold = 0;
    end else if (m_dir != 0) begin
      cm     = 1;
      tgt    = step(m_sel, cnt, m_dir);
      m_dir  = 0;
      m_hold = 0;
    end else if (ae) begin
      if (m_hold == HOLD - 1) begin
        cm     = 1;
        tgt    = step(m_sel, cnt, 1);
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end
    echg = cm && (tgt != m_sel);
    if (cm) m_sel = tgt;
    if (rise[0] && rise[1]) m_dir = 0;
    else if (rise[0])       m_dir = 1;
    else if (rise[1])       m_dir = -1;
    esel = m_sel;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit bn;
    bit bp;
    bit ae;
    int cnt;
    int sel;
    bit chg;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit bn, input bit bp, input bit ae, input int cnt,
                     input int sel, input bit chg);
    vec_t v;
    v.bn = bn; v.bp = bp; v.ae = ae; v.cnt = cnt; v.sel = sel; v.chg = chg;
    vt.push_back(v);
  endtask

  initial begin
    bit  rb_n, rb_p, rae;
    int  rcnt, esel;
    bit  echg;

    // Hold next 3+ frames: debounced at 2nd sample, commits at 3rd, no repeat.
    add(1,0,0,73, 0,0); add(1,0,0,73, 0,0); add(1,0,0,73, 1,1); add(1,0,0,73, 1,0);
    add(0,0,0,73, 1,0); add(0,0,0,73, 1,0);
    // prev 1->0, then prev again wraps 0->72
    add(0,1,0,73, 1,0); add(0,1,0,73, 1,0); add(0,0,0,73, 0,1); add(0,0,0,73, 0,0);
    add(0,1,0,73, 0,0); add(0,1,0,73, 0,0); add(0,1,0,73,72,1); add(0,0,0,73,72,0);
    // next wraps 72->0
    add(1,0,0,73,72,0); add(1,0,0,73,72,0); add(0,0,0,73, 0,1); add(0,0,0,73, 0,0);
    // single-sample glitch, then simultaneous press cancels
    add(1,0,0,73, 0,0); add(0,0,0,73, 0,0); add(0,0,0,73, 0,0);
    add(1,1,0,73, 0,0); add(1,1,0,73, 0,0); add(1,1,0,73, 0,0);
    add(0,0,0,73, 0,0); add(0,0,0,73, 0,0); add(0,0,0,73, 0,0);
    // auto mode: advance every 4 frames; manual commit restarts the interval
    add(0,0,1,73, 0,0); add(0,0,1,73, 0,0); add(0,0,1,73, 0,0); add(0,0,1,73, 1,1);
    add(0,0,1,73, 1,0); add(0,0,1,73, 1,0); add(0,0,1,73, 1,0); add(0,0,1,73, 2,1);
    add(1,0,1,73, 2,0); add(1,0,1,73, 2,0); add(1,0,1,73, 3,1);
    add(0,0,1,73, 3,0); add(0,0,1,73, 3,0); add(0,0,1,73, 3,0); add(0,0,1,73, 4,1);
    // count shrinks below selector: next lands on 0
    add(1,0,0, 3, 4,0); add(1,0,0, 3, 4,0); add(0,0,0, 3, 0,1); add(0,0,0, 3, 0,0);
    // reach 50 via prev with count=51, then count=10 and next -> 0
    add(0,1,0,51, 0,0); add(0,1,0,51, 0,0); add(0,0,0,51,50,1); add(0,0,0,51,50,0);
    add(1,0,0,10,50,0); add(1,0,0,10,50,0); add(0,0,0,10, 0,1); add(0,0,0,51, 0,0);
    // back to 50, then count=10 and prev -> 9
    add(0,1,0,51, 0,0); add(0,1,0,51, 0,0); add(0,0,0,51,50,1); add(0,0,0,51,50,0);
    add(0,1,0,10,50,0); add(0,1,0,10,50,0); add(0,0,0,10, 9,1); add(0,0,0,10, 9,0);
    // count=0 forces 0 silently; a pending next then commits to 0 at count=1 without a pulse
    add(0,0,0, 0, 0,0); add(1,0,0, 0, 0,0); add(1,0,0, 0, 0,0); add(0,0,0, 0, 0,0);
    add(0,0,0, 1, 0,0); add(0,0,0,73, 0,0);

    @(negedge clk);
    apply_reset();
    for (int i = 0; i < vt.size(); i++) begin
      do_frame(vt[i].bn, vt[i].bp, vt[i].ae, vt[i].cnt, vt[i].sel, vt[i].chg,
               $sformatf("vec%0d", i));
    end

    // Async reset mid-cycle with a next request pending.
    apply_reset();
    do_frame(1,0,0,73, 0,0, "ar0");
    do_frame(1,0,0,73, 0,0, "ar1");
    do_frame(1,0,0,73, 1,1, "ar2");
    do_frame(0,0,0,73, 1,0, "ar3");
    do_frame(0,0,0,73, 1,0, "ar4");
    do_frame(1,0,0,73, 1,0, "ar5");
    do_frame(1,0,0,73, 1,0, "ar6");
    btn_next = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", selector, 0);
    check("async_rst_chg", changed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(0,0,0,73, 0,0, "ar_post0");
    do_frame(0,0,0,73, 0,0, "ar_post1");

    // Randomized frames against the reference model.
    apply_reset();
    model_reset();
    rb_n = 0; rb_p = 0; rae = 0; rcnt = 73;
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 3) == 0) rb_n = ~rb_n;
      if ($urandom_range(0, 3) == 0) rb_p = ~rb_p;
      if ($urandom_range(0, 19) == 0) rae = ~rae;
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0:       rcnt = 73;
          1:       rcnt = $urandom_range(0, 12);
          2:       rcnt = 255;
          default: rcnt = $urandom_range(0, 255);
        endcase
      end
      model_frame(rb_n, rb_p, rae, rcnt, esel, echg);
      do_frame(rb_n, rb_p, rae, rcnt, esel, echg, $sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
